// File: rtl/master_tod_pps_snapshot.sv
// Master ToD PPS snapshot: on each enabled PPS rising edge, a 96-bit ToD value is
// pushed into a small FIFO. The FIFO head, status and control registers are read
// through an Avalon-MM CSR slave.
// Optional feature macro: MASTER_TOD_SNAP_PERIOD_EN adds a PPS period counter at
// address 6. Without it, address 6 reads 0.
module master_tod_pps_snapshot #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned STALE_LIMIT = 1024
) (
    input  logic        i_clk_tod,
    input  logic        i_tod_rst,
    input  logic        i_pps,
    input  logic        i_tod_valid,
    input  logic [95:0] i_tod_data,
    input  logic [3:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        csr_waitrequest,
    output logic        o_snap_irq
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned STALE_W   = $clog2(STALE_LIMIT + 1);
    localparam logic [4:0]  DEPTH_LVL = 5'(FIFO_DEPTH);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_LIMIT);

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_SEC_HI = 4'd1;
    localparam logic [3:0] ADDR_SEC_LO = 4'd2;
    localparam logic [3:0] ADDR_NS     = 4'd3;
    localparam logic [3:0] ADDR_FRAC   = 4'd4;
    localparam logic [3:0] ADDR_POP    = 4'd5;
    localparam logic [3:0] ADDR_PERIOD = 4'd6;
    localparam logic [3:0] ADDR_CTRL   = 4'd7;

    logic [95:0]        tod_hold_q;
    logic               pps_q;
    logic [95:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [4:0]         level_q;
    logic               overflow_q;
    logic [STALE_W-1:0] stale_cnt_q;
    logic               ctrl_enable_q;
    logic               ctrl_irq_en_q;
    logic               rd_pending_q;
    logic [31:0]        rd_data_q;

    logic        pps_edge;
    logic        push;
    logic        pop;
    logic        push_ok;
    logic        drop;
    logic        fifo_empty;
    logic        fifo_full;
    logic        tod_stale;
    logic [95:0] snap;
    logic [95:0] head;
    logic [31:0] period_val;
    logic [31:0] rd_mux;

    assign pps_edge   = i_pps & ~pps_q;
    assign push       = pps_edge & ctrl_enable_q;
    assign fifo_empty = (level_q == 5'd0);
    assign fifo_full  = (level_q == DEPTH_LVL);
    assign pop        = csr_write && (csr_address == ADDR_POP) && !fifo_empty;
    // A pop in the same cycle frees the slot the push lands in, so full is not a drop.
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign snap       = i_tod_valid ? i_tod_data : tod_hold_q;
    assign head       = fifo_mem[rd_ptr_q];
    assign tod_stale  = (stale_cnt_q == STALE_MAX);

    // Snapshot storage; contents are don't-care while empty since head reads are masked.
    always_ff @(posedge i_clk_tod) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= snap;
        end
    end

    // Core state: ToD hold, PPS edge history, FIFO pointers/level, flags and CTRL.
    always_ff @(posedge i_clk_tod) begin
        if (i_tod_rst) begin
            tod_hold_q    <= '0;
            pps_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            stale_cnt_q   <= '0;
            ctrl_enable_q <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
        end else begin
            pps_q <= i_pps;
            if (i_tod_valid) begin
                tod_hold_q <= i_tod_data;
            end

            if (i_tod_valid) begin
                stale_cnt_q <= '0;
            end else if (!tod_stale) begin
                stale_cnt_q <= stale_cnt_q + 1'b1;
            end

            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                level_q <= level_q + 5'd1;
            end else if (pop && !push_ok) begin
                level_q <= level_q - 5'd1;
            end

            // Write-one-to-clear; a same-cycle drop wins so no overflow is lost.
            if (csr_write && (csr_address == ADDR_STATUS) && csr_writedata[8]) begin
                overflow_q <= 1'b0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end

            if (csr_write && (csr_address == ADDR_CTRL)) begin
                ctrl_enable_q <= csr_writedata[0];
                ctrl_irq_en_q <= csr_writedata[1];
            end
        end
    end

`ifdef MASTER_TOD_SNAP_PERIOD_EN
    logic [31:0] period_cnt_q;
    logic [31:0] period_q;
    logic        period_armed_q;

    // Cycles between consecutive enabled PPS edges; disabling re-arms the measurement.
    always_ff @(posedge i_clk_tod) begin
        if (i_tod_rst) begin
            period_cnt_q   <= '0;
            period_q       <= '0;
            period_armed_q <= 1'b0;
        end else if (push) begin
            if (period_armed_q) begin
                period_q <= (period_cnt_q == 32'hFFFF_FFFF) ? period_cnt_q
                                                            : period_cnt_q + 32'd1;
            end
            period_cnt_q   <= '0;
            period_armed_q <= 1'b1;
        end else begin
            if (period_cnt_q != 32'hFFFF_FFFF) begin
                period_cnt_q <= period_cnt_q + 32'd1;
            end
            if (!ctrl_enable_q) begin
                period_armed_q <= 1'b0;
            end
        end
    end

    assign period_val = period_q;
`else
    assign period_val = 32'd0;
`endif

    // CSR read decode; head fields read 0 while the FIFO is empty.
    always_comb begin
        rd_mux = 32'd0;
        case (csr_address)
            ADDR_STATUS: rd_mux = {22'd0, tod_stale, overflow_q, 3'd0, level_q};
            ADDR_SEC_HI: rd_mux = fifo_empty ? 32'd0 : {16'd0, head[95:80]};
            ADDR_SEC_LO: rd_mux = fifo_empty ? 32'd0 : head[79:48];
            ADDR_NS:     rd_mux = fifo_empty ? 32'd0 : head[47:16];
            ADDR_FRAC:   rd_mux = fifo_empty ? 32'd0 : {16'd0, head[15:0]};
            ADDR_PERIOD: rd_mux = period_val;
            ADDR_CTRL:   rd_mux = {30'd0, ctrl_irq_en_q, ctrl_enable_q};
            default:     rd_mux = 32'd0;
        endcase
    end

    // Two-cycle read: capture data in the waitrequest cycle, present it in the next.
    always_ff @(posedge i_clk_tod) begin
        if (i_tod_rst) begin
            rd_pending_q <= 1'b0;
            rd_data_q    <= '0;
        end else if (csr_read && !rd_pending_q) begin
            rd_pending_q <= 1'b1;
            rd_data_q    <= rd_mux;
        end else begin
            rd_pending_q <= 1'b0;
            rd_data_q    <= '0;
        end
    end

    // Outputs are forced low while reset is held so a pending read is abandoned at once.
    assign csr_waitrequest = csr_read & ~rd_pending_q & ~i_tod_rst;
    assign csr_readdata    = i_tod_rst ? 32'd0 : rd_data_q;
    assign o_snap_irq      = ctrl_irq_en_q & ~fifo_empty & ~i_tod_rst;

    logic unused_wdata;
    assign unused_wdata = ^{csr_writedata[31:9], csr_writedata[7:2]};

endmodule
